// File: rtl/regwrt_pkg.sv
// regwrt_pkg: shared widths, write-request type and drop-counter limit for the write-port scheduler
package regwrt_pkg;
  localparam int NUM_W = 3;
  localparam int DATA_W = 16;
  localparam logic [7:0] DROP_MAX = 8'hFF;
  typedef struct packed {
    logic valid;
    logic [NUM_W-1:0] num;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/wr_pending_fifo.sv
// wr_pending_fifo: ordered queue of deferred secondary writes with cancel-by-register and youngest-match lookup
module wr_pending_fifo
  import regwrt_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  wr_req_t           i_push_req,
  input  logic              i_pop,
  input  logic              i_cancel,
  input  logic [NUM_W-1:0]  i_cancel_num,
  input  logic [NUM_W-1:0]  i_lk_num,
  output wr_req_t           o_head,
  output logic [CW-1:0]     o_count,
  output logic [CW-1:0]     o_cancel_cnt,
  output logic              o_lk_hit,
  output logic [DATA_W-1:0] o_lk_data
);
  wr_req_t r_ent [DEPTH];
  logic [PW-1:0] r_head, r_tail, w_idx;
  logic [CW-1:0] r_count;
  logic [DEPTH-1:0] w_kill;
  // Walk entries oldest to youngest so the last match seen is the youngest
  always_comb begin
    w_kill = '0;
    o_cancel_cnt = '0;
    o_lk_hit = 1'b0;
    o_lk_data = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = i_cancel && r_ent[i].valid && r_ent[i].num == i_cancel_num;
      o_cancel_cnt = o_cancel_cnt + CW'(w_kill[i]);
      w_idx = r_head + PW'(i);
      if (CW'(i) < r_count && r_ent[w_idx].valid && r_ent[w_idx].num == i_lk_num) begin
        o_lk_hit = 1'b1;
        o_lk_data = r_ent[w_idx].data;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (w_kill[i]) r_ent[i].valid <= 1'b0;
      if (i_pop) begin
        r_ent[r_head].valid <= 1'b0;
        r_head <= r_head + PW'(1);
      end
      if (i_push) begin
        r_ent[r_tail] <= i_push_req;
        r_tail <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_head = r_ent[r_head];
  assign o_count = r_count;
endmodule

// File: rtl/regwrt_port_scheduler.sv
// regwrt_port_scheduler: arbitrates the register-file write port between writeback (primary)
// and a queued secondary source, with same-register cancellation and bypass lookup
module regwrt_port_scheduler
  import regwrt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write,
  input  logic [NUM_W-1:0]  wb_num,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sec_valid,
  input  logic [NUM_W-1:0]  sec_num,
  input  logic [DATA_W-1:0] sec_data,
  output logic              sec_ready,
  output logic              stall_out,
  output logic              rf_write,
  output logic [NUM_W-1:0]  rf_num,
  output logic [DATA_W-1:0] rf_data,
  input  logic [NUM_W-1:0]  lk_num,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data,
  output logic [7:0]        drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  wr_req_t w_head, w_sel;
  logic [CW-1:0] w_count, w_cancel_cnt;
  logic w_fifo_hit, w_rf_match, w_acc, w_empty, w_kill, w_pop, w_direct, w_push;
  logic [DATA_W-1:0] w_fifo_data;
  logic [8:0] w_drop_sum;
  logic r_rf_write;
  logic [NUM_W-1:0] r_rf_num;
  logic [DATA_W-1:0] r_rf_data;
  logic [7:0] r_drop;
  assign w_empty = w_count == '0;
  assign sec_ready = w_count < CW'(DEPTH);
  assign stall_out = w_count >= CW'(DEPTH - 1);
  assign w_acc = sec_valid && sec_ready;
  // A secondary write racing a primary write to the same register is older and therefore stale
  assign w_kill = wb_write && w_acc && sec_num == wb_num;
  assign w_pop = !wb_write && !w_empty;
  assign w_direct = !wb_write && w_empty && w_acc;
  assign w_push = w_acc && !w_direct && !(w_kill && w_empty);
  assign w_sel = wb_write ? wr_req_t'{1'b1, wb_num, wb_data}
               : w_pop ? w_head
               : wr_req_t'{w_direct, sec_num, sec_data};
  assign w_drop_sum = {1'b0, r_drop} + 9'(w_cancel_cnt) + 9'(w_kill);
  wr_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_push_req(wr_req_t'{!w_kill, sec_num, sec_data}),
    .i_pop(w_pop),
    .i_cancel(wb_write),
    .i_cancel_num(wb_num),
    .i_lk_num(lk_num),
    .o_head(w_head),
    .o_count(w_count),
    .o_cancel_cnt(w_cancel_cnt),
    .o_lk_hit(w_fifo_hit),
    .o_lk_data(w_fifo_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_write <= 1'b0;
      r_rf_num <= '0;
      r_rf_data <= '0;
      r_drop <= '0;
    end else begin
      r_rf_write <= w_sel.valid;
      if (w_sel.valid) begin
        r_rf_num <= w_sel.num;
        r_rf_data <= w_sel.data;
      end
      r_drop <= w_drop_sum > 9'(DROP_MAX) ? DROP_MAX : w_drop_sum[7:0];
    end
  end
  assign w_rf_match = r_rf_write && r_rf_num == lk_num;
  assign lk_hit = w_fifo_hit || w_rf_match;
  assign lk_data = w_fifo_hit ? w_fifo_data : w_rf_match ? r_rf_data : '0;
  assign rf_write = r_rf_write;
  assign rf_num = r_rf_num;
  assign rf_data = r_rf_data;
  assign drop_cnt = r_drop;
endmodule

// File: tb/tb_regwrt_port_scheduler.sv
// tb_regwrt_port_scheduler: queue-based reference model feeds a scoreboard of expected register-file writes
module tb_regwrt_port_scheduler;
  logic clk = 0, rst = 1;
  logic wb_write = 0, sec_valid = 0;
  logic [2:0] wb_num = 0, sec_num = 0, lk_num = 0;
  logic [15:0] wb_data = 0, sec_data = 0;
  logic sec_ready, stall_out, rf_write, lk_hit;
  logic [2:0] rf_num;
  logic [15:0] rf_data, lk_data;
  logic [7:0] drop_cnt;

  regwrt_port_scheduler #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_write(wb_write), .wb_num(wb_num), .wb_data(wb_data),
    .sec_valid(sec_valid), .sec_num(sec_num), .sec_data(sec_data),
    .sec_ready(sec_ready), .stall_out(stall_out),
    .rf_write(rf_write), .rf_num(rf_num), .rf_data(rf_data),
    .lk_num(lk_num), .lk_hit(lk_hit), .lk_data(lk_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit [2:0] n; bit [15:0] d; } ent_t;
  typedef struct { int c; bit [2:0] n; bit [15:0] d; } exp_t;
  ent_t mq[$];
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, m_drop = 0;
  bit m_rf_write = 0;
  bit [2:0] m_rf_num = 0;
  bit [15:0] m_rf_data = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every presented write must be the oldest expected write, in the expected cycle
  initial forever begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (rf_write === 1'b1) begin
      if (sb.size() == 0) chk("extra_wr", rf_write, 0);
      else begin
        e = sb.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_num", rf_num, e.n);
        chk("wr_data", rf_data, e.d);
      end
    end
  end

  task automatic step(bit w, bit [2:0] wn, bit [15:0] wd, bit s, bit [2:0] sn, bit [15:0] sd, bit [2:0] ln);
    int sz;
    bit rdy, acc, hit, iss;
    bit [2:0] in_n;
    bit [15:0] hd, in_d;
    ent_t e;
    @(negedge clk);
    wb_write = w; wb_num = wn; wb_data = wd;
    sec_valid = s; sec_num = sn; sec_data = sd; lk_num = ln;
    #1;
    sz = mq.size();
    rdy = sz < 4;
    acc = s && rdy;
    hit = 0; hd = 0;
    for (int i = sz - 1; i >= 0; i--)
      if (!hit && mq[i].v && mq[i].n == ln) begin hit = 1; hd = mq[i].d; end
    if (!hit && m_rf_write && m_rf_num == ln) begin hit = 1; hd = m_rf_data; end
    chk("sec_ready", sec_ready, rdy);
    chk("stall_out", stall_out, sz >= 3);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("lk_hit", lk_hit, hit);
    chk("lk_data", lk_data, hd);
    iss = 0; in_n = 0; in_d = 0;
    if (w) begin
      iss = 1; in_n = wn; in_d = wd;
      foreach (mq[i]) if (mq[i].v && mq[i].n == wn) begin mq[i].v = 0; m_drop++; end
      if (acc) begin
        if (sn == wn) begin
          m_drop++;
          if (sz > 0) mq.push_back('{0, sn, sd});
        end else mq.push_back('{1, sn, sd});
      end
    end else if (sz > 0) begin
      e = mq.pop_front();
      if (e.v) begin iss = 1; in_n = e.n; in_d = e.d; end
      if (acc) mq.push_back('{1, sn, sd});
    end else if (acc) begin
      iss = 1; in_n = sn; in_d = sd;
    end
    if (m_drop > 255) m_drop = 255;
    m_rf_write = iss;
    if (iss) begin
      m_rf_num = in_n; m_rf_data = in_d;
      sb.push_back('{cyc + 1, in_n, in_d});
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_write = 0; sec_valid = 0;
    rst = 0;
    #1;
    chk("rst_rf_write", rf_write, 0);
    chk("rst_sec_ready", sec_ready, 1);
    chk("rst_stall", stall_out, 0);
    chk("rst_drop", drop_cnt, 0);
    mq.delete(); sb.delete();
    m_rf_write = 0; m_drop = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  initial begin
    do_reset();
    // direct path on an empty queue
    step(0, 0, 0, 1, 2, 16'h1234, 2);
    step(0, 0, 0, 0, 0, 0, 2);
    chk("direct_lk", lk_data, 16'h1234);
    chk("direct_ready", sec_ready, 1);
    idle(1);
    // contention: primary owns the port while secondaries pile up
    for (int k = 0; k < 4; k++) step(1, 1, 16'hAAAA, 1, 3 + k, 16'h0100 + k, 0);
    step(1, 1, 16'hAAAA, 1, 7, 16'h7777, 0);
    chk("full_ready", sec_ready, 0);
    chk("full_stall", stall_out, 1);
    idle(6);
    // cancellation of a queued entry
    step(1, 0, 0, 1, 5, 16'h0001, 0);
    step(1, 0, 0, 1, 6, 16'h0002, 0);
    step(1, 5, 16'h00FF, 0, 0, 0, 0);
    idle(4);
    chk("cancel_drop", drop_cnt, 1);
    // same-cycle kill on an empty queue
    step(1, 2, 16'h2222, 1, 2, 16'h3333, 0);
    idle(2);
    chk("kill_drop", drop_cnt, 2);
    // youngest-match lookup
    step(1, 0, 0, 1, 4, 16'h0010, 0);
    step(1, 0, 0, 1, 4, 16'h0020, 0);
    step(0, 0, 0, 0, 0, 0, 4);
    chk("lk4_hit", lk_hit, 1);
    chk("lk4_data", lk_data, 16'h0020);
    step(0, 0, 0, 0, 0, 0, 7);
    chk("lk7_hit", lk_hit, 0);
    chk("lk7_data", lk_data, 0);
    idle(3);
    // reset with three entries pending: none of them may be written afterwards
    for (int k = 0; k < 3; k++) step(1, 7, 16'h0777, 1, k, 16'h0E00 + k, 0);
    do_reset();
    idle(6);
    // randomized traffic with one mid-stream reset
    for (int it = 0; it < 400; it++) begin
      if (it == 200) do_reset();
      step($urandom_range(0, 9) < 4, 3'($urandom), 16'($urandom),
           $urandom_range(0, 9) < 6, 3'($urandom), 16'($urandom), 3'($urandom));
    end
    idle(8);
    // drop counter saturation
    repeat (260) step(1, 3, 16'h0303, 1, 3, 16'h0404, 3);
    idle(2);
    chk("drop_sat", drop_cnt, 8'hFF);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regwrt_port_scheduler.md
Name: regwrt_port_scheduler

Overview:
Shares the single register-file write port between the writeback stage (primary, always wins) and a secondary deferred-write source (delayed B-operand writes and other late writers). Secondary writes that lose arbitration are held in a small ordered queue and drained when the port is idle. Writes from the primary source cancel any stale queued writes to the same register. The block also provides a bypass lookup so operand fetch sees pending values, and raises a stall when the queue nears full. It sits between the writeback stage and the register file.

Parameters:
DEPTH, 4, secondary queue entries; must be a power of two, at least 2
DATA_W, 16, write data width
NUM_W, 3, register number width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
wb_write  in  1  primary write request
wb_num  in  NUM_W  primary destination register
wb_data  in  DATA_W  primary write data
sec_valid  in  1  secondary write request
sec_num  in  NUM_W  secondary destination register
sec_data  in  DATA_W  secondary write data
sec_ready  out  1  secondary accepted this cycle when sec_valid&&sec_ready; equals (count<DEPTH), from state only
stall_out  out  1  count>=DEPTH-1; pipeline must hold issue
rf_write  out  1  registered write enable to register file
rf_num  out  NUM_W  registered write register
rf_data  out  DATA_W  registered write data
lk_num  in  NUM_W  bypass lookup register number
lk_hit  out  1  combinational: a pending write to lk_num exists
lk_data  out  DATA_W  combinational: youngest pending value for lk_num (0 when no hit)
drop_cnt  out  8  saturating count of cancelled secondary writes

Behaviour:
- Reset (rst low, asynchronous): rf_write=0, rf_num=0, rf_data=0, queue empty (head=tail=count=0, all valid bits 0), drop_cnt=0. Hence sec_ready=1 and stall_out=0. Reset mid-operation discards all pending entries; no write is issued for them.
- Latency: a selected request appears on rf_* exactly 1 cycle later. rf_write is 0 on any cycle with nothing selected.
- Per-cycle selection, in priority order:
  1) wb_write=1: the primary request is issued.
  2) Otherwise, if the queue is non-empty: pop the head. If the head is valid it is issued; if it was cancelled, rf_write=0 next cycle (the cycle is consumed).
  3) Otherwise, if the queue is empty and sec_valid: the secondary request is issued directly and is not enqueued.
- Enqueue: an accepted secondary request not issued directly is pushed at the tail. Push and pop may occur in the same cycle; count is unchanged.
- Pointers wrap modulo DEPTH.
- Cancellation, when wb_write=1 with wb_num=N:
  - Every valid queued entry with num N has its valid bit cleared.
  - An accepted secondary request in the same cycle with sec_num=N is treated as older. It is enqueued already invalid, or dropped if it would have been issued directly.
  - Each cancelled or dropped entry increments drop_cnt, saturating at 255. Multiple cancellations in one cycle add their total.
- Lookup, for lk_num: the youngest valid queue entry with a matching num wins. Otherwise, if rf_write=1 and rf_num matches, return rf_data. Otherwise lk_hit=0.
- Full queue: sec_ready=0 and the secondary source must hold its request. A request presented with sec_ready=0 is ignored.
- Secondary ordering: queued entries are issued in FIFO order, so no two secondary writes to the same register are reordered.

Decomposition:
- Package regwrt_pkg:
  - Constants NUM_W=3 and DATA_W=16.
  - typedef wr_req_t {logic valid; logic [NUM_W-1:0] num; logic [DATA_W-1:0] data;}.
  - Saturation constant DROP_MAX=8'hFF.
- One sub-module, wr_pending_fifo. It holds the entry array, head/tail/count, push/pop, the per-entry cancel-by-num match, and the youngest-match lookup search.
- The top level holds the arbitration mux, output registers and drop counter.

Test Plan:
- Reset: assert rst=0 mid-stream with 3 entries queued -> rf_write=0, sec_ready=1, stall_out=0, drop_cnt=0 immediately, with no later writes for the discarded entries.
- Direct path: queue empty, sec_valid=1, num=2, data=16'h1234, wb_write=0 -> next cycle rf_write=1, rf_num=2, rf_data=16'h1234; count stays 0.
- Contention: wb_write=1 (num=1, 16'hAAAA) for 4 cycles while sec issues num=3,4,5,6 -> rf_* shows R1 four times, stall_out=1 at count=3, sec_ready=0 at count=4; then R3..R6 drain in order.
- Cancellation: queue holds R5=16'h0001 and R6=16'h0002, then wb_write num=5 data=16'h00FF -> R5 entry yields an rf_write=0 slot when popped, R6 is still written, drop_cnt=1.
- Same-cycle kill: empty queue, wb_write num=2 and sec_valid num=2 together -> only the primary write is issued, nothing is queued, drop_cnt increments by 1.
- Lookup: queue holds R4=16'h0010 then R4=16'h0020, lk_num=4 -> lk_hit=1, lk_data=16'h0020. With lk_num=7 and no match -> lk_hit=0, lk_data=0.
